// File: rtl/axi_master_connector_pkg.sv
// -----------------------------------------------------------------------------
// axi_conf: shared AXI4 configuration package.
// Provides the default bus widths, the BURST/RESP encodings and the packed
// channel / request / response structs used by internal AXI plumbing.
// -----------------------------------------------------------------------------
package axi_conf;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned STRB_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned ID_WIDTH     = 8;
  localparam int unsigned AWUSER_WIDTH = 1;
  localparam int unsigned WUSER_WIDTH  = 1;
  localparam int unsigned BUSER_WIDTH  = 1;
  localparam int unsigned ARUSER_WIDTH = 1;
  localparam int unsigned RUSER_WIDTH  = 1;
  localparam int unsigned ATOP_WIDTH   = 6;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0]     id;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [ATOP_WIDTH-1:0]   atop;
    logic [AWUSER_WIDTH-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [STRB_WIDTH-1:0]  strb;
    logic                   last;
    logic [WUSER_WIDTH-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]    id;
    logic [1:0]             resp;
    logic [BUSER_WIDTH-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]     id;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [ARUSER_WIDTH-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]    id;
    logic [DATA_WIDTH-1:0]  data;
    logic [1:0]             resp;
    logic                   last;
    logic [RUSER_WIDTH-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_master_connector_skid_buf.sv
// -----------------------------------------------------------------------------
// axi_conn_skid_buf: full-throughput two-entry skid buffer (valid/ready).
// Main register M drives the output; skid register S catches the beat that
// arrives while M is stalled. in_ready is registered and equals !S.valid.
// Ports:
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready/in_data     upstream side
//   out_valid/out_ready/out_data  downstream side
// -----------------------------------------------------------------------------
module axi_conn_skid_buf #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             accept;
  logic             drain;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    accept    = in_valid & in_ready_q;
    drain     = m_valid_q & out_ready;

    if (drain) begin
      if (s_valid_q) begin
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else begin
        m_valid_d = 1'b0;
      end
    end

    // accept implies S is empty, so S->M refill and accept never collide
    if (accept) begin
      if (!m_valid_q || drain) begin
        m_data_d  = in_data;
        m_valid_d = 1'b1;
      end else begin
        s_data_d  = in_data;
        s_valid_d = 1'b1;
      end
    end

    in_ready_d = !s_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // payload registers carry no reset; they only load on accept/refill
  always_ff @(posedge clk) begin
    m_data_q <= m_data_d;
    s_data_q <= s_data_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;

endmodule

// File: rtl/axi_master_connector.sv
// -----------------------------------------------------------------------------
// axi_master_connector: drives flat m_axi_* AXI4 master ports from an internal
// axi_conf::req_t / resp_t pair. AW, W and AR each pass through a skid buffer.
// B and R are combinational passthrough unless AXI_MASTER_CONN_RSP_REG_EN is
// defined, in which case they also go through skid buffers (+1 cycle latency).
// Ports:
//   clk, rst                 clock, async active-high reset
//   axi_req_i / axi_resp_o   internal request / response structs
//   m_axi_aw* / m_axi_w* / m_axi_ar*   outgoing request channels
//   m_axi_b* / m_axi_r*                incoming response channels
// aw.atop is not forwarded.
// -----------------------------------------------------------------------------
module axi_master_connector
  import axi_conf::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned AWUSER_WIDTH = 1,
  parameter int unsigned WUSER_WIDTH  = 1,
  parameter int unsigned BUSER_WIDTH  = 1,
  parameter int unsigned ARUSER_WIDTH = 1,
  parameter int unsigned RUSER_WIDTH  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  req_t                    axi_req_i,
  output resp_t                   axi_resp_o,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic [3:0]              m_axi_awregion,
  output logic [AWUSER_WIDTH-1:0] m_axi_awuser,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic [WUSER_WIDTH-1:0]  m_axi_wuser,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic [BUSER_WIDTH-1:0]  m_axi_buser,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic [RUSER_WIDTH-1:0]  m_axi_ruser,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  // len+size+burst+lock+cache+prot+qos+region = 29 bits
  localparam int unsigned AW_W = ID_WIDTH + ADDR_WIDTH + 29 + AWUSER_WIDTH;
  localparam int unsigned W_W  = DATA_WIDTH + STRB_WIDTH + 1 + WUSER_WIDTH;
  localparam int unsigned AR_W = ID_WIDTH + ADDR_WIDTH + 29 + ARUSER_WIDTH;

  logic [AW_W-1:0] aw_in, aw_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [AR_W-1:0] ar_in, ar_out;
  logic            aw_ready, w_ready, ar_ready;
  logic            unused_atop;

  assign unused_atop = ^axi_req_i.aw.atop;

  assign aw_in = {axi_req_i.aw.id, axi_req_i.aw.addr, axi_req_i.aw.len,
                  axi_req_i.aw.size, axi_req_i.aw.burst, axi_req_i.aw.lock,
                  axi_req_i.aw.cache, axi_req_i.aw.prot, axi_req_i.aw.qos,
                  axi_req_i.aw.region, axi_req_i.aw.user};
  assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
          m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos,
          m_axi_awregion, m_axi_awuser} = aw_out;

  assign w_in = {axi_req_i.w.data, axi_req_i.w.strb, axi_req_i.w.last,
                 axi_req_i.w.user};
  assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser} = w_out;

  assign ar_in = {axi_req_i.ar.id, axi_req_i.ar.addr, axi_req_i.ar.len,
                  axi_req_i.ar.size, axi_req_i.ar.burst, axi_req_i.ar.lock,
                  axi_req_i.ar.cache, axi_req_i.ar.prot, axi_req_i.ar.qos,
                  axi_req_i.ar.region, axi_req_i.ar.user};
  assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
          m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos,
          m_axi_arregion, m_axi_aruser} = ar_out;

  axi_conn_skid_buf #(.WIDTH(AW_W)) u_aw_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (axi_req_i.aw_valid),
    .in_ready  (aw_ready),
    .in_data   (aw_in),
    .out_valid (m_axi_awvalid),
    .out_ready (m_axi_awready),
    .out_data  (aw_out)
  );

  axi_conn_skid_buf #(.WIDTH(W_W)) u_w_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (axi_req_i.w_valid),
    .in_ready  (w_ready),
    .in_data   (w_in),
    .out_valid (m_axi_wvalid),
    .out_ready (m_axi_wready),
    .out_data  (w_out)
  );

  axi_conn_skid_buf #(.WIDTH(AR_W)) u_ar_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (axi_req_i.ar_valid),
    .in_ready  (ar_ready),
    .in_data   (ar_in),
    .out_valid (m_axi_arvalid),
    .out_ready (m_axi_arready),
    .out_data  (ar_out)
  );

`ifdef AXI_MASTER_CONN_RSP_REG_EN
  localparam int unsigned B_W = ID_WIDTH + 2 + BUSER_WIDTH;
  localparam int unsigned R_W = ID_WIDTH + DATA_WIDTH + 2 + 1 + RUSER_WIDTH;

  logic [B_W-1:0] b_out;
  logic [R_W-1:0] r_out;
  logic           b_valid, r_valid;

  // response buffers run slave->master: external port is the upstream side
  axi_conn_skid_buf #(.WIDTH(B_W)) u_b_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_axi_bvalid),
    .in_ready  (m_axi_bready),
    .in_data   ({m_axi_bid, m_axi_bresp, m_axi_buser}),
    .out_valid (b_valid),
    .out_ready (axi_req_i.b_ready),
    .out_data  (b_out)
  );

  axi_conn_skid_buf #(.WIDTH(R_W)) u_r_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_axi_rvalid),
    .in_ready  (m_axi_rready),
    .in_data   ({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser}),
    .out_valid (r_valid),
    .out_ready (axi_req_i.r_ready),
    .out_data  (r_out)
  );

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.w_ready  = w_ready;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.b_valid  = b_valid;
    {axi_resp_o.b.id, axi_resp_o.b.resp, axi_resp_o.b.user} = b_out;
    axi_resp_o.r_valid  = r_valid;
    {axi_resp_o.r.id, axi_resp_o.r.data, axi_resp_o.r.resp,
     axi_resp_o.r.last, axi_resp_o.r.user} = r_out;
  end
`else
  assign m_axi_bready = axi_req_i.b_ready;
  assign m_axi_rready = axi_req_i.r_ready;

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.w_ready  = w_ready;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.b_valid  = m_axi_bvalid;
    axi_resp_o.b.id     = m_axi_bid;
    axi_resp_o.b.resp   = m_axi_bresp;
    axi_resp_o.b.user   = m_axi_buser;
    axi_resp_o.r_valid  = m_axi_rvalid;
    axi_resp_o.r.id     = m_axi_rid;
    axi_resp_o.r.data   = m_axi_rdata;
    axi_resp_o.r.resp   = m_axi_rresp;
    axi_resp_o.r.last   = m_axi_rlast;
    axi_resp_o.r.user   = m_axi_ruser;
  end
`endif

endmodule

// File: tb/tb_axi_master_connector.sv
// -----------------------------------------------------------------------------
// Self-checking bench for axi_master_connector. Each request channel is
// modelled as an ordered queue of accepted beats with capacity two; the
// response path is checked from a vector table (default build) or a short
// hand sequence (AXI_MASTER_CONN_RSP_REG_EN build).
// -----------------------------------------------------------------------------
module tb_axi_master_connector;
  import axi_conf::*;

  localparam int unsigned AWW = 8 + 32 + 29 + 1;
  localparam int unsigned WW  = 32 + 4 + 1 + 1;
  localparam int unsigned ARW = 8 + 32 + 29 + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  req_t  req;
  resp_t resp;

  logic [7:0]  m_axi_awid;    logic [31:0] m_axi_awaddr;  logic [7:0] m_axi_awlen;
  logic [2:0]  m_axi_awsize;  logic [1:0]  m_axi_awburst; logic       m_axi_awlock;
  logic [3:0]  m_axi_awcache; logic [2:0]  m_axi_awprot;  logic [3:0] m_axi_awqos;
  logic [3:0]  m_axi_awregion; logic [0:0] m_axi_awuser;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;   logic [3:0]  m_axi_wstrb;   logic       m_axi_wlast;
  logic [0:0]  m_axi_wuser;   logic        m_axi_wvalid,  m_axi_wready;
  logic [7:0]  m_axi_bid;     logic [1:0]  m_axi_bresp;   logic [0:0] m_axi_buser;
  logic        m_axi_bvalid,  m_axi_bready;
  logic [7:0]  m_axi_arid;    logic [31:0] m_axi_araddr;  logic [7:0] m_axi_arlen;
  logic [2:0]  m_axi_arsize;  logic [1:0]  m_axi_arburst; logic       m_axi_arlock;
  logic [3:0]  m_axi_arcache; logic [2:0]  m_axi_arprot;  logic [3:0] m_axi_arqos;
  logic [3:0]  m_axi_arregion; logic [0:0] m_axi_aruser;
  logic        m_axi_arvalid, m_axi_arready;
  logic [7:0]  m_axi_rid;     logic [31:0] m_axi_rdata;   logic [1:0] m_axi_rresp;
  logic        m_axi_rlast;   logic [0:0]  m_axi_ruser;
  logic        m_axi_rvalid,  m_axi_rready;

  axi_master_connector #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .ID_WIDTH   (8)
  ) dut (
    .clk(clk), .rst(rst), .axi_req_i(req), .axi_resp_o(resp),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awregion(m_axi_awregion), .m_axi_awuser(m_axi_awuser),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wuser(m_axi_wuser), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: per-channel beat queues ----------------
  logic [AWW-1:0] aw_q[$];
  logic [WW-1:0]  w_q[$];
  logic [ARW-1:0] ar_q[$];
  logic [WW-1:0]  w_seen[$];
  logic [ARW-1:0] ar_seen[$];
  bit live = 0;  // set once a clock edge has passed with rst low
  bit aw_in_hs_g, w_in_hs_g, ar_in_hs_g;

  function automatic logic [AWW-1:0] pack_aw(input aw_chan_t a);
    return {a.id, a.addr, a.len, a.size, a.burst, a.lock, a.cache, a.prot, a.qos, a.region, a.user};
  endfunction
  function automatic logic [ARW-1:0] pack_ar(input ar_chan_t a);
    return {a.id, a.addr, a.len, a.size, a.burst, a.lock, a.cache, a.prot, a.qos, a.region, a.user};
  endfunction
  function automatic logic [WW-1:0] pack_w(input w_chan_t a);
    return {a.data, a.strb, a.last, a.user};
  endfunction
  function automatic logic [AWW-1:0] dut_aw();
    return {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
            m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion, m_axi_awuser};
  endfunction
  function automatic logic [ARW-1:0] dut_ar();
    return {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
            m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion, m_axi_aruser};
  endfunction
  function automatic logic [WW-1:0] dut_w();
    return {m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser};
  endfunction

  // Check request channels against the model, then advance one clock.
  task automatic tick();
    bit aw_in, aw_out, w_in, w_out, ar_in, ar_out;
    logic [AWW-1:0] aw_new;
    logic [WW-1:0]  w_new, w_got;
    logic [ARW-1:0] ar_new, ar_got;
    #1;
    check("aw_valid", m_axi_awvalid, aw_q.size() > 0);
    if (aw_q.size() > 0) check("aw_payload", dut_aw(), aw_q[0]);
    check("aw_ready", resp.aw_ready, live && aw_q.size() < 2);
    check("w_valid", m_axi_wvalid, w_q.size() > 0);
    if (w_q.size() > 0) check("w_payload", dut_w(), w_q[0]);
    check("w_ready", resp.w_ready, live && w_q.size() < 2);
    check("ar_valid", m_axi_arvalid, ar_q.size() > 0);
    if (ar_q.size() > 0) check("ar_payload", dut_ar(), ar_q[0]);
    check("ar_ready", resp.ar_ready, live && ar_q.size() < 2);

    aw_in  = req.aw_valid && live && aw_q.size() < 2;
    aw_out = aw_q.size() > 0 && m_axi_awready;
    w_in   = req.w_valid && live && w_q.size() < 2;
    w_out  = w_q.size() > 0 && m_axi_wready;
    ar_in  = req.ar_valid && live && ar_q.size() < 2;
    ar_out = ar_q.size() > 0 && m_axi_arready;
    aw_new = pack_aw(req.aw);
    w_new  = pack_w(req.w);
    ar_new = pack_ar(req.ar);
    w_got  = dut_w();
    ar_got = dut_ar();

    @(posedge clk);
    aw_in_hs_g = 0; w_in_hs_g = 0; ar_in_hs_g = 0;
    if (rst) begin
      aw_q.delete(); w_q.delete(); ar_q.delete();
      live = 0;
    end else begin
      if (aw_out) void'(aw_q.pop_front());
      if (aw_in) aw_q.push_back(aw_new);
      if (w_out) begin void'(w_q.pop_front()); w_seen.push_back(w_got); end
      if (w_in) w_q.push_back(w_new);
      if (ar_out) begin void'(ar_q.pop_front()); ar_seen.push_back(ar_got); end
      if (ar_in) ar_q.push_back(ar_new);
      aw_in_hs_g = aw_in; w_in_hs_g = w_in; ar_in_hs_g = ar_in;
      live = 1;
    end
    #1;
  endtask

  task automatic rand_payloads();
    req.aw.id = 8'($urandom); req.aw.addr = $urandom; req.aw.len = 8'($urandom);
    req.aw.size = 3'($urandom); req.aw.burst = 2'($urandom); req.aw.lock = 1'($urandom);
    req.aw.cache = 4'($urandom); req.aw.prot = 3'($urandom); req.aw.qos = 4'($urandom);
    req.aw.region = 4'($urandom); req.aw.atop = 6'($urandom); req.aw.user = 1'($urandom);
    req.w.data = $urandom; req.w.strb = 4'($urandom); req.w.last = 1'($urandom);
    req.w.user = 1'($urandom);
    req.ar.id = 8'($urandom); req.ar.addr = $urandom; req.ar.len = 8'($urandom);
    req.ar.size = 3'($urandom); req.ar.burst = 2'($urandom); req.ar.lock = 1'($urandom);
    req.ar.cache = 4'($urandom); req.ar.prot = 3'($urandom); req.ar.qos = 4'($urandom);
    req.ar.region = 4'($urandom); req.ar.user = 1'($urandom);
  endtask

  typedef struct {
    logic        rvalid; logic [31:0] rdata; logic [1:0] rresp; logic [7:0] rid;
    logic        rlast;  logic        r_ready;
    logic        bvalid; logic [1:0]  bresp; logic [7:0] bid;   logic       b_ready;
    logic        e_rvalid; logic [31:0] e_rdata; logic [1:0] e_rresp; logic [7:0] e_rid;
    logic        e_rlast;  logic        e_rready;
    logic        e_bvalid; logic [1:0]  e_bresp; logic [7:0] e_bid;   logic       e_bready;
  } rsp_vec_t;

  initial begin
    rsp_vec_t tbl[4];
    int k;
    int n;
    logic [ARW-1:0] pp;
    logic pv, pr;

    tbl[0] = '{1, 32'hDEAD_BEEF, 2'b10, 8'h11, 1, 1, 0, 2'b00, 8'h00, 0,
               1, 32'hDEAD_BEEF, 2'b10, 8'h11, 1, 1, 0, 2'b00, 8'h00, 0};
    tbl[1] = '{0, 32'h0000_0000, 2'b00, 8'h00, 0, 0, 1, 2'b11, 8'hA5, 1,
               0, 32'h0000_0000, 2'b00, 8'h00, 0, 0, 1, 2'b11, 8'hA5, 1};
    tbl[2] = '{1, 32'h1234_5678, 2'b01, 8'hFF, 0, 0, 1, 2'b01, 8'h3C, 0,
               1, 32'h1234_5678, 2'b01, 8'hFF, 0, 0, 1, 2'b01, 8'h3C, 0};
    tbl[3] = '{1, 32'hFFFF_FFFF, 2'b00, 8'h80, 1, 1, 1, 2'b10, 8'h01, 1,
               1, 32'hFFFF_FFFF, 2'b00, 8'h80, 1, 1, 1, 2'b10, 8'h01, 1};

    req = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_buser = '0; m_axi_bvalid = 0;
    m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
    m_axi_ruser = '0; m_axi_rvalid = 0;

    // ---- reset held 3 cycles with aw_valid high ----
    #1 rst = 1;
    rand_payloads();
    req.aw_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_awvalid", m_axi_awvalid, 0);
      check("rst_aw_ready", resp.aw_ready, 0);
    end
    rst = 0;
    req.aw_valid = 0;
    check("aw_ready_before_edge", resp.aw_ready, 0);
    tick();
    check("aw_ready_after_release", resp.aw_ready, 1);

    // ---- single AW ----
    m_axi_awready = 1;
    req.aw.id = 8'h05; req.aw.addr = 32'h1000_0040; req.aw.len = 8'd3; req.aw.size = 3'd2;
    req.aw.burst = BURST_INCR; req.aw_valid = 1;
    tick();
    req.aw_valid = 0;
    check("single_awvalid", m_axi_awvalid, 1);
    check("single_awaddr", m_axi_awaddr, 32'h1000_0040);
    check("single_awid", m_axi_awid, 8'h05);
    check("single_awlen", m_axi_awlen, 8'd3);
    check("single_aw_ready", resp.aw_ready, 1);
    tick();
    check("single_awvalid_gone", m_axi_awvalid, 0);

    // ---- W backpressure ----
    w_seen.delete();
    m_axi_wready = 0;
    k = 0;
    req.w = '{data: 32'hA0, strb: 4'hF, last: 1'b0, user: 1'b0};
    req.w_valid = 1;
    for (int c = 0; c < 10 && k < 2; c++) begin
      tick();
      if (w_in_hs_g) begin k++; req.w.data = 32'hA0 + 32'(k); req.w.last = (k == 3); end
    end
    tick();
    check("w_accepted_under_stall", k, 2);
    check("w_ready_full", resp.w_ready, 0);
    m_axi_wready = 1;
    for (int c = 0; c < 20 && w_seen.size() < 4; c++) begin
      tick();
      if (w_in_hs_g) begin
        k++;
        if (k == 4) req.w_valid = 0;
        else begin req.w.data = 32'hA0 + 32'(k); req.w.last = (k == 3); end
      end
    end
    req.w_valid = 0;
    check("w_beats_out", w_seen.size(), 4);
    for (int i = 0; i < 4 && i < w_seen.size(); i++) begin
      check("w_order_data", w_seen[i][WW-1 -: 32], 32'hA0 + 32'(i));
      check("w_order_last", w_seen[i][1], i == 3);
    end
    tick();

    // ---- AR throughput with toggling arready ----
    ar_seen.delete();
    n = 0;
    req.ar = '0; req.ar.id = 8'd0; req.ar.addr = 32'h2000_0000; req.ar_valid = 1;
    for (int c = 0; c < 100 && ar_seen.size() < 16; c++) begin
      m_axi_arready = (c % 2) == 0;
      pv = m_axi_arvalid; pr = m_axi_arready; pp = dut_ar();
      tick();
      if (pv && !pr) begin
        check("ar_hold_valid", m_axi_arvalid, 1);
        check("ar_hold_payload", dut_ar(), pp);
      end
      if (ar_in_hs_g) begin
        n++;
        if (n == 16) req.ar_valid = 0;
        else begin req.ar.id = 8'(n); req.ar.addr = 32'h2000_0000 + 32'(n * 64); end
      end
    end
    req.ar_valid = 0;
    check("ar_handshakes", ar_seen.size(), 16);
    for (int i = 0; i < 16 && i < ar_seen.size(); i++) begin
      check("ar_order_id", ar_seen[i][ARW-1 -: 8], 8'(i));
      check("ar_order_addr", ar_seen[i][ARW-9 -: 32], 32'h2000_0000 + 32'(i * 64));
    end
    m_axi_arready = 1;
    tick();

    // ---- randomized traffic on all request channels ----
    for (int c = 0; c < 300; c++) begin
      rand_payloads();
      req.aw_valid = 1'($urandom); req.w_valid = 1'($urandom); req.ar_valid = 1'($urandom);
      m_axi_awready = ($urandom % 4) != 0;
      m_axi_wready  = 1'($urandom);
      m_axi_arready = ($urandom % 4) == 0;
      tick();
    end
    req.aw_valid = 0; req.w_valid = 0; req.ar_valid = 0;
    m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1;
    for (int c = 0; c < 4; c++) tick();

    // ---- mid-operation reset with AW full ----
    m_axi_awready = 0;
    req.aw_valid = 1;
    for (int c = 0; c < 10 && aw_q.size() < 2; c++) begin rand_payloads(); tick(); end
    req.aw_valid = 0;
    check("aw_full_before_rst", resp.aw_ready, 0);
    #2 rst = 1;
    #1;
    check("aw_async_drop", m_axi_awvalid, 0);
    aw_q.delete(); w_q.delete(); ar_q.delete(); live = 0;
    tick(); tick();
    rst = 0;
    m_axi_awready = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("no_stale_aw", m_axi_awvalid, 0);
    end

    // ---- response path ----
`ifndef AXI_MASTER_CONN_RSP_REG_EN
    for (int i = 0; i < 4; i++) begin
      m_axi_rvalid = tbl[i].rvalid; m_axi_rdata = tbl[i].rdata; m_axi_rresp = tbl[i].rresp;
      m_axi_rid = tbl[i].rid; m_axi_rlast = tbl[i].rlast; req.r_ready = tbl[i].r_ready;
      m_axi_bvalid = tbl[i].bvalid; m_axi_bresp = tbl[i].bresp; m_axi_bid = tbl[i].bid;
      req.b_ready = tbl[i].b_ready;
      #1;
      check("tbl_r_valid", resp.r_valid, tbl[i].e_rvalid);
      check("tbl_r_data", resp.r.data, tbl[i].e_rdata);
      check("tbl_r_resp", resp.r.resp, tbl[i].e_rresp);
      check("tbl_r_id", resp.r.id, tbl[i].e_rid);
      check("tbl_r_last", resp.r.last, tbl[i].e_rlast);
      check("tbl_rready", m_axi_rready, tbl[i].e_rready);
      check("tbl_b_valid", resp.b_valid, tbl[i].e_bvalid);
      check("tbl_b_resp", resp.b.resp, tbl[i].e_bresp);
      check("tbl_b_id", resp.b.id, tbl[i].e_bid);
      check("tbl_bready", m_axi_bready, tbl[i].e_bready);
      tick();
    end
`else
    req.r_ready = 1;
    m_axi_rvalid = 1; m_axi_rdata = 32'hDEAD_BEEF; m_axi_rresp = 2'b10;
    m_axi_rid = 8'h03; m_axi_rlast = 1;
    #1;
    check("rreg_rready", m_axi_rready, 1);
    check("rreg_not_same_cycle", resp.r_valid, 0);
    tick();
    m_axi_rvalid = 0;
    check("rreg_r_valid", resp.r_valid, 1);
    check("rreg_r_data", resp.r.data, 32'hDEAD_BEEF);
    check("rreg_r_resp", resp.r.resp, 2'b10);
    tick();
    check("rreg_drained", resp.r_valid, 0);
    req.r_ready = 0;
    m_axi_rvalid = 1; m_axi_rdata = 32'h0000_0001;
    tick();
    m_axi_rdata = 32'h0000_0002;
    tick();
    m_axi_rvalid = 0;
    check("rreg_stall_rready", m_axi_rready, 0);
    check("rreg_stall_data", resp.r.data, 32'h0000_0001);
    req.r_ready = 1;
    tick();
    check("rreg_second_data", resp.r.data, 32'h0000_0002);
    check("rreg_second_valid", resp.r_valid, 1);
    tick();
    check("rreg_empty", resp.r_valid, 0);
    check("rreg_rready_back", m_axi_rready, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
